// File: rtl/aes_decrypt.sv
// Iterative AES-128 inverse cipher, one round per clock.
// The state byte layout matches the encryptor: byte0 = bits[127:120], column-major.
module aes_decrypt #(
    parameter bit DEC_KEY_IN = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] Block,
    input  logic [127:0] Key,
    output logic         ready,
    output logic         done,
    output logic [127:0] Result,
    output logic [2:0]   o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYEXP = 3'd1,
        S_INIT   = 3'd2,
        S_ROUND  = 3'd3,
        S_FINAL  = 3'd4
    } state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {x, 3'b000};
        return SBOX[11'd2047 - idx -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [10:0] idx;
        idx = {x, 3'b000};
        return INV_SBOX[11'd2047 - idx -: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] rc;
        case (n)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
    endfunction

    function automatic logic [127:0] forward_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot_word(k[31:0]) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undoes one forward step: the previous w3 is recovered first because w0 depends on it.
    function automatic logic [127:0] inverse_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot_word(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = inv_sbox(s[127 - 8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2    = xt(a[i]);
            x4    = xt(x2);
            x8    = xt(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32*c -: 32] = inv_mix_column(s[127 - 32*c -: 32]);
        end
        return o;
    endfunction

    state_t         r_state;
    state_t         w_next;
    logic [127:0]   r_st;
    logic [127:0]   r_rk;
    logic [3:0]     r_cnt;
    logic [127:0]   r_result;
    logic           r_done;

    logic [127:0]   w_isr_isb;
    logic [127:0]   w_round_st;
    logic [127:0]   w_rk_fwd;
    logic [127:0]   w_rk_inv;
    logic [7:0]     w_inv_rc;

    assign w_isr_isb  = inv_sub_bytes(inv_shift_rows(r_st));
    assign w_round_st = inv_mix_columns(w_isr_isb ^ r_rk);
    assign w_rk_fwd   = forward_expand(r_rk, rcon(r_cnt));
    // INIT always steps back from round key 10, whatever the counter holds on entry.
    assign w_inv_rc   = (r_state == S_INIT) ? 8'h36 : rcon(r_cnt);
    assign w_rk_inv   = inverse_expand(r_rk, w_inv_rc);

    assign ready       = (r_state == S_IDLE);
    assign done        = r_done;
    assign Result      = r_result;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start && ready) w_next = DEC_KEY_IN ? S_INIT : S_KEYEXP;
            S_KEYEXP: if (r_cnt == 4'd10) w_next = S_INIT;
            S_INIT:   w_next = S_ROUND;
            S_ROUND:  if (r_cnt == 4'd1) w_next = S_FINAL;
            S_FINAL:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_st     <= '0;
            r_rk     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_st  <= Block;
                        r_rk  <= Key;
                        r_cnt <= 4'd1;
                    end
                end
                S_KEYEXP: begin
                    r_rk  <= w_rk_fwd;
                    r_cnt <= r_cnt + 4'd1;
                end
                S_INIT: begin
                    r_st  <= r_st ^ r_rk;
                    r_rk  <= w_rk_inv;
                    r_cnt <= 4'd9;
                end
                S_ROUND: begin
                    r_st  <= w_round_st;
                    r_rk  <= w_rk_inv;
                    r_cnt <= r_cnt - 4'd1;
                end
                S_FINAL: begin
                    r_result <= w_isr_isb ^ r_rk;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decrypt.sv
// Directed bench for aes_decrypt: FIPS-197 vectors, ignored starts, back-to-back jobs,
// asynchronous abort, and the pre-expanded-key variant.
module tb_aes_decrypt;

    localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] RK1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] RK2  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         start_a, start_b;
    logic [127:0] block_a, key_a, block_b, key_b;
    logic         ready_a, done_a, ready_b, done_b;
    logic [127:0] result_a, result_b;
    logic [2:0]   dbg_a, dbg_b;

    aes_decrypt #(.DEC_KEY_IN(1'b0)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .Block(block_a), .Key(key_a),
        .ready(ready_a), .done(done_a), .Result(result_a), .o_dbg_state(dbg_a)
    );

    aes_decrypt #(.DEC_KEY_IN(1'b1)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .Block(block_b), .Key(key_b),
        .ready(ready_b), .done(done_b), .Result(result_b), .o_dbg_state(dbg_b)
    );

    // scoreboard
    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] exp_q[$];

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic score(input bit sel, input string tag);
        logic [127:0] res;
        res = sel ? result_b : result_a;
        check({tag, "_queue"}, 128'(exp_q.size()), 128'd1);
        if (exp_q.size() > 0) check({tag, "_result"}, res, exp_q.pop_front());
    endtask

    // drivers
    task automatic scramble();
        block_a = {$urandom, $urandom, $urandom, $urandom};
        key_a   = {$urandom, $urandom, $urandom, $urandom};
        block_b = {$urandom, $urandom, $urandom, $urandom};
        key_b   = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drive_start(input bit sel, input logic [127:0] blk, input logic [127:0] key);
        if (sel) begin
            start_b = 1'b1; block_b = blk; key_b = key;
        end else begin
            start_a = 1'b1; block_a = blk; key_a = key;
        end
    endtask

    task automatic run_job(input bit sel, input logic [127:0] blk, input logic [127:0] key,
                           input logic [127:0] exp, input int lat, input string tag);
        int n_done;
        int done_edge;
        n_done = 0;
        done_edge = 0;
        drive_start(sel, blk, key);
        exp_q.push_back(exp);
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        scramble();
        for (int e = 1; e <= lat + 3; e++) begin
            @(posedge clk); #1;
            if (sel ? done_b : done_a) begin
                n_done++;
                if (done_edge == 0) begin
                    done_edge = e;
                    score(sel, tag);
                end
            end
        end
        check({tag, "_latency"}, 128'(done_edge), 128'(lat));
        check({tag, "_ndone"}, 128'(n_done), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n_done;
        int done_edge;

        reset   = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        block_a = '0; key_a = '0; block_b = '0; key_b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_ready_a",  128'(ready_a), 128'd1);
        check("rst_done_a",   128'(done_a), 128'd0);
        check("rst_result_a", result_a, 128'h0);
        check("rst_ready_b",  128'(ready_b), 128'd1);
        check("rst_result_b", result_b, 128'h0);

        // C.1 vector with ignored starts at edges 3 and 10, then a start in the done cycle
        drive_start(1'b0, CT1, K1);
        exp_q.push_back(PT1);
        @(posedge clk); #1;
        start_a = 1'b0;
        scramble();
        n_done = 0;
        done_edge = 0;
        for (int e = 1; e <= 21; e++) begin
            @(posedge clk); #1;
            if (done_a) begin
                n_done++;
                done_edge = e;
                score(1'b0, "job1");
            end
            if (e == 12) check("job1_busy_ready", 128'(ready_a), 128'd0);
            if (e == 2 || e == 9) drive_start(1'b0, CT2, K2);
            else start_a = 1'b0;
        end
        check("job1_latency", 128'(done_edge), 128'd21);
        check("job1_ndone", 128'(n_done), 128'd1);
        check("job1_done_ready", 128'(ready_a), 128'd1);

        drive_start(1'b0, CT2, K2);
        exp_q.push_back(PT2);
        @(posedge clk); #1;
        start_a = 1'b0;
        scramble();
        check("b2b_done_pulse", 128'(done_a), 128'd0);
        check("b2b_result_held", result_a, PT1);
        n_done = 0;
        done_edge = 0;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk); #1;
            if (done_a) begin
                n_done++;
                if (done_edge == 0) begin
                    done_edge = e;
                    score(1'b0, "job2");
                end
            end
        end
        check("job2_latency", 128'(done_edge), 128'd21);
        check("job2_ndone", 128'(n_done), 128'd1);

        // asynchronous abort at edge 12 of a job
        drive_start(1'b0, CT1, K1);
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int e = 1; e <= 11; e++) @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_ready",  128'(ready_a), 128'd1);
        check("abort_done",   128'(done_a), 128'd0);
        check("abort_result", result_a, 128'h0);
        check("abort_state",  128'(dbg_a), 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        n_done = 0;
        for (int e = 1; e <= 25; e++) begin
            @(posedge clk); #1;
            if (done_a) n_done++;
        end
        check("abort_no_done", 128'(n_done), 128'd0);
        run_job(1'b0, CT2, K2, PT2, 21, "fresh");

        // pre-expanded round key 10
        run_job(1'b1, CT1, RK1, PT1, 11, "rk10_c1");
        run_job(1'b1, CT2, RK2, PT2, 11, "rk10_b");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
